pubkey_extractor: RTL and testbench

- Downstream stage of the systemizer: once the systemizer has reduced the matrix to systematic form [I | T], this block reads the shared matrix RAM.
- It skips the identity columns and streams the T part out as BLOCK-bit words over a valid/ready interface.
- The stream is the public-key serializer input.
- It shares the systemizer's RAM read port, used only after systemizer done && success.

---
 rtl/pubkey_pkg.sv | 40 ++++
 rtl/pk_skid_fifo.sv | 54 +++++
 rtl/pubkey_extractor.sv | 173 +++++++++++++++++
 tb/tb_pubkey_extractor.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pubkey_pkg.sv
// Shared constants, FSM encoding and sizing helpers for the public-key extractor.
package pubkey_pkg;

  // Never returns 0, so the result can always size a vector.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return (result == 0) ? 1 : result;
  endfunction

  function automatic int unsigned calc_wpr(input int unsigned cols, input int unsigned block);
    return cols / block;
  endfunction

  function automatic int unsigned calc_idw(input int unsigned rows, input int unsigned block);
    return rows / block;
  endfunction

  function automatic int unsigned calc_addr_w(input int unsigned rows, input int unsigned cols,
                                              input int unsigned block);
    return clog2(rows * (cols / block));
  endfunction

  localparam int unsigned DEF_ROWS  = 8;
  localparam int unsigned DEF_COLS  = 16;
  localparam int unsigned DEF_BLOCK = 4;

  localparam int unsigned WPR    = calc_wpr(DEF_COLS, DEF_BLOCK);
  localparam int unsigned IDW    = calc_idw(DEF_ROWS, DEF_BLOCK);
  localparam int unsigned ADDR_W = calc_addr_w(DEF_ROWS, DEF_COLS, DEF_BLOCK);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } pk_state_e;

endpackage

// File: rtl/pk_skid_fifo.sv
// Two-entry FIFO between the one-cycle RAM read pipe and the output handshake.
module pk_skid_fifo #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == 2'd2);
  assign empty    = (count_q == 2'd0);
  assign count    = count_q;

endmodule

// File: rtl/pubkey_extractor.sv
// Streams the T part of a systematic [I | T] matrix from the shared RAM as BLOCK-bit words.
// Define IDENTITY_CHECK_EN to also read and verify the identity part (adds id_err).
module pubkey_extractor
  import pubkey_pkg::*;
#(
  parameter int unsigned ROWS  = DEF_ROWS,
  parameter int unsigned COLS  = DEF_COLS,
  parameter int unsigned BLOCK = DEF_BLOCK
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       rd_en,
  output logic [calc_addr_w(ROWS, COLS, BLOCK)-1:0]  rd_addr,
  input  logic [BLOCK-1:0]                           rd_data,
  output logic [BLOCK-1:0]                           out_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       out_last
`ifdef IDENTITY_CHECK_EN
  ,
  output logic                                       id_err
`endif
);

  localparam int unsigned NW    = calc_wpr(COLS, BLOCK);
  localparam int unsigned NI    = calc_idw(ROWS, BLOCK);
  localparam int unsigned AW    = calc_addr_w(ROWS, COLS, BLOCK);
  localparam int unsigned RW    = clog2(ROWS);
  localparam int unsigned WW    = clog2(NW);
  localparam bit          HAS_T = (NW > NI);

`ifdef IDENTITY_CHECK_EN
  localparam logic [WW-1:0] FIRST_WORD = '0;
`else
  localparam logic [WW-1:0] FIRST_WORD = WW'(NI);
`endif
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(NW - 1);

  pk_state_e      state_q, state_d;
  logic [RW-1:0]  row_q;
  logic [WW-1:0]  word_q;
  logic           inflight_q;
  logic           rsp_last_q;
  logic           rsp_push_q;
  logic           at_last;
  logic           rd_space;
  logic           pop;
  logic           start_ok;
  logic           fifo_full;
  logic           fifo_empty;
  logic [1:0]     fifo_count;
  logic [BLOCK:0] fifo_head;

  assign at_last  = (row_q == LAST_ROW) && (word_q == LAST_WORD);
  assign pop      = out_valid && out_ready;
  assign start_ok = (state_q == StIdle) && start;

  // Issue only while FIFO words plus the read in flight, less this cycle's pop, stay under two.
  assign rd_space = fifo_full ? (pop && !inflight_q) : (!inflight_q || fifo_empty || pop);

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = HAS_T ? StRead : StDone;
      end
      StRead: begin
        busy  = 1'b1;
        rd_en = rd_space;
        if (rd_space && at_last) state_d = StDrain;
      end
      StDrain: begin
        busy = 1'b1;
        if ((fifo_count == 2'd0) && !inflight_q) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_addr = (state_q == StRead) ? (AW'(row_q) * AW'(NW) + AW'(word_q)) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      row_q      <= '0;
      word_q     <= '0;
      inflight_q <= 1'b0;
      rsp_last_q <= 1'b0;
      rsp_push_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      rsp_last_q <= rd_en && at_last;
      rsp_push_q <= rd_en && (word_q >= WW'(NI));
      if (start_ok) begin
        row_q  <= '0;
        word_q <= FIRST_WORD;
      end else if (rd_en) begin
        if (word_q == LAST_WORD) begin
          word_q <= FIRST_WORD;
          row_q  <= row_q + RW'(1);
        end else begin
          word_q <= word_q + WW'(1);
        end
      end
    end
  end

  pk_skid_fifo #(
    .WIDTH (BLOCK + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push_q),
    .push_data ({rsp_last_q, rd_data}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[BLOCK-1:0];
  assign out_last  = fifo_head[BLOCK] && out_valid;

`ifdef IDENTITY_CHECK_EN
  logic [RW-1:0]    rsp_row_q;
  logic [WW-1:0]    rsp_word_q;
  logic             id_err_q;
  logic [BLOCK-1:0] id_exp;

  // Row r of the identity has only bit (r mod BLOCK) of word (r / BLOCK) set.
  always_comb begin
    id_exp = '0;
    if (32'(rsp_word_q) == (32'(rsp_row_q) / BLOCK)) begin
      id_exp = BLOCK'(1) << (32'(rsp_row_q) % BLOCK);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_row_q  <= '0;
      rsp_word_q <= '0;
      id_err_q   <= 1'b0;
    end else begin
      if (rd_en) begin
        rsp_row_q  <= row_q;
        rsp_word_q <= word_q;
      end
      if (start_ok) begin
        id_err_q <= 1'b0;
      end else if (inflight_q && !rsp_push_q && (rd_data != id_exp)) begin
        id_err_q <= 1'b1;
      end
    end
  end

  assign id_err = id_err_q;
`endif

endmodule

// File: tb/tb_pubkey_extractor.sv
// Directed bench for pubkey_extractor with a scoreboard queue and immediate assertions.
// Build with IDENTITY_CHECK_EN defined to cover the identity-verification variant.
`timescale 1ns/1ps
module tb_pubkey_extractor;
  import pubkey_pkg::*;

  localparam int unsigned AW  = calc_addr_w(8, 16, 4);
  localparam int unsigned AW0 = calc_addr_w(8, 8, 4);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, busy, done, rd_en, out_valid, out_ready, out_last;
  logic [AW-1:0] rd_addr;
  logic [3:0]    rd_data, out_data;

  logic           start0, busy0, done0, rd_en0, out_valid0, out_last0;
  logic [AW0-1:0] rd_addr0;
  logic [3:0]     rd_data0, out_data0;
`ifdef IDENTITY_CHECK_EN
  logic           id_err, id_err0;
`endif

  assign rd_data0 = 4'h0;

  logic [3:0]    ram [32];
  int            checks = 0;
  int            errors = 0;
  logic [4:0]    exp_q [$];
  logic [AW-1:0] addr_q [$];
  int            rx_cnt, done_cnt, done0_cnt, valid0_cnt, rd0_cnt, stall_cnt, d_mark;
  logic          prev_stall, prev_busy;
  logic [4:0]    prev_word, mon_e;

  pubkey_extractor #(.ROWS(8), .COLS(16), .BLOCK(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
`ifdef IDENTITY_CHECK_EN
    ,
    .id_err    (id_err)
`endif
  );

  pubkey_extractor #(.ROWS(8), .COLS(8), .BLOCK(4)) u_empty (
    .clk       (clk),
    .rst       (rst),
    .start     (start0),
    .busy      (busy0),
    .done      (done0),
    .rd_en     (rd_en0),
    .rd_addr   (rd_addr0),
    .rd_data   (rd_data0),
    .out_data  (out_data0),
    .out_valid (out_valid0),
    .out_ready (1'b1),
    .out_last  (out_last0)
`ifdef IDENTITY_CHECK_EN
    ,
    .id_err    (id_err0)
`endif
  );

  // Synchronous RAM: data appears one cycle after the read strobe.
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", {out_last, out_data}, prev_word);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", out_data, mon_e[3:0]);
          chk("out_last", out_last, mon_e[4]);
        end
        rx_cnt++;
      end
      if (out_valid && !out_ready) stall_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
      if (done) begin
        done_cnt++;
        chk("busy_at_done", busy, 0);
        chk("busy_before_done", prev_busy, 1);
      end
      prev_busy = busy;
      if (rd_en) addr_q.push_back(rd_addr);
      if (out_valid0) valid0_cnt++;
      if (rd_en0) rd0_cnt++;
      if (done0) done0_cnt++;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic push_expected();
    rx_cnt = 0;
    for (int r = 0; r < 8; r++) begin
      for (int w = 2; w < 4; w++) begin
        exp_q.push_back({(r == 7 && w == 3), 4'((r * 4 + w) % 16)});
      end
    end
  endtask

  task automatic wait_done(input bit toggle, input string tag);
    int   d0;
    bit   seen;
    logic [3:0] pat;
    d0   = done_cnt;
    seen = 1'b0;
    pat  = 4'b1001;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      out_ready = toggle ? pat[c % 4] : 1'b1;
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, seen, 1);
    out_ready = 1'b1;
  endtask

  task automatic check_stream(input string tag, input int done_exp);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_words"}, rx_cnt, 16);
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_done_cnt"}, done_cnt, done_exp);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start0 = 1'b0; out_ready = 1'b1; rd_data = 4'h0;
    rx_cnt = 0; done_cnt = 0; done0_cnt = 0; valid0_cnt = 0; rd0_cnt = 0; stall_cnt = 0;
    prev_stall = 1'b0; prev_busy = 1'b0; prev_word = '0; mon_e = '0;
    // T words hold a mod 16; identity words hold a proper one-hot identity.
    for (int a = 0; a < 32; a++) begin
      if ((a % 4) >= 2) ram[a] = 4'(a % 16);
      else ram[a] = ((a % 4) == ((a / 4) / 4)) ? 4'(1 << ((a / 4) % 4)) : 4'h0;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
`ifdef IDENTITY_CHECK_EN
    chk("rst_id_err", id_err, 0);
`endif
    rst = 1'b0;

    // Full stream with the consumer always ready.
    addr_q.delete();
    push_expected();
    pulse_start();
`ifndef IDENTITY_CHECK_EN
    @(posedge clk); #1;
    chk("lat_valid_early", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_valid_first", out_valid, 1);
`endif
    wait_done(1'b0, "done_a");
    check_stream("a", 1);
`ifdef IDENTITY_CHECK_EN
    chk("a_rd_count", addr_q.size(), 32);
    for (int i = 0; i < 32 && i < addr_q.size(); i++) chk("a_rd_addr", addr_q[i], i);
    chk("a_id_err", id_err, 0);
`else
    chk("a_rd_count", addr_q.size(), 16);
    for (int i = 0; i < 16 && i < addr_q.size(); i++) begin
      chk("a_rd_addr", addr_q[i], (i / 2) * 4 + 2 + (i % 2));
    end
`endif

    // Backpressure pattern 1,0,0,1.
    push_expected();
    stall_cnt = 0;
    d_mark = done_cnt;
    pulse_start();
    wait_done(1'b1, "done_b");
    check_stream("b", d_mark + 1);
    chk("b_stalls_seen", (stall_cnt > 0), 1);

    // Reset after five words, then a clean restart.
    push_expected();
    pulse_start();
    for (int c = 0; c < 100 && rx_cnt < 5; c++) begin
      @(posedge clk); #1;
    end
    chk("c_reach5", (rx_cnt >= 5), 1);
    rst = 1'b1;
    #1;
    chk("c_rst_busy", busy, 0);
    chk("c_rst_done", done, 0);
    chk("c_rst_rd_en", rd_en, 0);
    chk("c_rst_rd_addr", rd_addr, 0);
    chk("c_rst_out_valid", out_valid, 0);
    chk("c_rst_out_last", out_last, 0);
    chk("c_rst_out_data", out_data, 0);
    exp_q.delete();
    d_mark = done_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("c_no_done", done_cnt, d_mark);
    push_expected();
    pulse_start();
    wait_done(1'b0, "done_c");
    check_stream("c", d_mark + 1);

    // Second start while busy is ignored.
    push_expected();
    d_mark = done_cnt;
    pulse_start();
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1'b0, "done_d");
    check_stream("d", d_mark + 1);
    repeat (6) @(posedge clk);
    #1;
    chk("d_no_restart", done_cnt, d_mark + 1);

`ifdef IDENTITY_CHECK_EN
    // Corrupt row 2, identity word 1: flagged, stream untouched.
    ram[9] = 4'h1;
    push_expected();
    pulse_start();
    wait_done(1'b0, "done_e");
    check_stream("e", done_cnt);
    chk("e_id_err_set", id_err, 1);
    ram[9] = 4'h0;
    push_expected();
    pulse_start();
    chk("e_id_err_clr", id_err, 0);
    wait_done(1'b0, "done_e2");
    check_stream("e2", done_cnt);
    chk("e2_id_err", id_err, 0);
`endif

    // No T part: done follows start directly, nothing is read or emitted.
    @(posedge clk);
    #1 start0 = 1'b1;
    chk("f_done_before", done0, 0);
    @(posedge clk);
    #1 start0 = 1'b0;
    chk("f_done_pulse", done0, 1);
    chk("f_busy", busy0, 0);
    @(posedge clk);
    #1;
    chk("f_done_low", done0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("f_valid_never", valid0_cnt, 0);
    chk("f_rd_never", rd0_cnt, 0);
    chk("f_done_cnt", done0_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
